mips_ctrl_exec: RTL and testbench

- Multicycle MIPS-I control-and-execute core slice: 5-state sequencer, main instruction decoder, ALU-function decoder and 32-bit integer ALU in one block.
- Sits between the Avalon bus front end (instruction/readdata, waitrequest) and the datapath (register file, PC, HI/LO, memory muxes).
- Drives every datapath strobe and produces the ALU result and branch condition.

---
 rtl/mips_ctrl_exec.sv | 244 ++++++++++++++++++++++++
 tb/tb_mips_ctrl_exec.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_exec.sv
// rtl/mips_ctrl_exec.sv - multicycle MIPS-I sequencer, decoder and ALU slice
module mips_ctrl_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        pc_zero,
  input  logic [31:0] instr_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [1:0]  addr_lo,
  output logic [2:0]  state,
  output logic        active,
  output logic [31:0] instr,
  output logic [31:0] alu_result,
  output logic        cond,
  output logic        memread,
  output logic        memwrite,
  output logic        regwrite,
  output logic        regdst,
  output logic        alusrc,
  output logic        signed_imm,
  output logic        branch,
  output logic        jump,
  output logic        regtojump,
  output logic        link,
  output logic        pctoadd,
  output logic        pcwrite,
  output logic        inwrite,
  output logic        memtoreg,
  output logic        loadimmed,
  output logic        hitoreg,
  output logic        lotoreg,
  output logic        dm_en,
  output logic        dm_signed,
  output logic [1:0]  dm_op,
  output logic [2:0]  extend_op,
  output logic [3:0]  byteenable
);

  typedef enum logic [2:0] {
    S_HALT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC1 = 3'd3, S_EXEC2 = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_SLTU,
    A_SLL, A_SRL, A_SRA, A_SLLV, A_SRLV, A_SRAV
  } alu_op_t;

  state_t      state_q, state_d;
  logic        active_q, active_d;
  logic [31:0] instr_q, instr_d;

  logic [5:0]  op, funct;
  logic [4:0]  rtf, shamt;
  alu_op_t     d_alu;
  logic        d_load, d_store, d_branch, d_jump, d_regtojump, d_regwrite, d_regdst;
  logic        d_link, d_alusrc, d_signed_imm, d_memtoreg, d_loadimmed, d_hitoreg;
  logic        d_lotoreg, d_dm_en, d_dm_signed;
  logic [1:0]  d_dm_op;
  logic [2:0]  d_extend_op;
  logic [31:0] alu_b;

  assign state  = state_q;
  assign active = active_q;
  // The bus readdata is the instruction while decoding; afterwards the latched copy.
  assign instr  = (state_q == S_DECODE) ? instr_in : instr_q;
  assign op     = instr[31:26];
  assign funct  = instr[5:0];
  assign rtf    = instr[20:16];
  assign shamt  = instr[10:6];

  // Sequencer next state: halt request beats advance, stall freezes everything else.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    instr_d  = instr_q;
    if (pc_zero && state_q != S_HALT) begin
      state_d  = S_HALT;
      active_d = 1'b0;
    end else if (!waitrequest) begin
      case (state_q)
        S_HALT:   begin state_d = S_FETCH; active_d = 1'b1; end
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin state_d = S_EXEC1; instr_d = instr_in; end
        S_EXEC1:  state_d = S_EXEC2;
        S_EXEC2:  state_d = S_FETCH;
        default:  state_d = S_HALT;
      endcase
    end
  end

  // Sequencer state, run flag and instruction latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_HALT;
      active_q <= 1'b0;
      instr_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      instr_q  <= instr_d;
    end
  end

  // Main and function decoder: instruction class flags independent of state.
  always_comb begin
    d_alu = A_ADD; d_load = 1'b0; d_store = 1'b0; d_branch = 1'b0; d_jump = 1'b0;
    d_regtojump = 1'b0; d_regwrite = 1'b0; d_regdst = 1'b0; d_link = 1'b0;
    d_alusrc = 1'b0; d_signed_imm = 1'b0; d_memtoreg = 1'b0; d_loadimmed = 1'b0;
    d_hitoreg = 1'b0; d_lotoreg = 1'b0; d_dm_en = 1'b0; d_dm_signed = 1'b0;
    d_dm_op = 2'b00; d_extend_op = 3'b000;
    case (op)
      6'd0: begin
        d_regwrite = 1'b1;
        d_regdst   = 1'b1;
        case (funct)
          6'd0:  d_alu = A_SLL;
          6'd2:  d_alu = A_SRL;
          6'd3:  d_alu = A_SRA;
          6'd4:  d_alu = A_SLLV;
          6'd6:  d_alu = A_SRLV;
          6'd7:  d_alu = A_SRAV;
          6'd33: d_alu = A_ADD;
          6'd35: d_alu = A_SUB;
          6'd36: d_alu = A_AND;
          6'd37: d_alu = A_OR;
          6'd38: d_alu = A_XOR;
          6'd42: d_alu = A_SLT;
          6'd43: d_alu = A_SLTU;
          6'd8:  begin d_jump = 1'b1; d_regtojump = 1'b1; d_regwrite = 1'b0; d_regdst = 1'b0; end
          6'd9:  begin d_jump = 1'b1; d_regtojump = 1'b1; d_link = 1'b1; end
          6'd16: d_hitoreg = 1'b1;
          6'd18: d_lotoreg = 1'b1;
          6'd17: begin d_regwrite = 1'b0; d_regdst = 1'b0; d_dm_en = 1'b1; d_dm_op = 2'b10; end
          6'd19: begin d_regwrite = 1'b0; d_regdst = 1'b0; d_dm_en = 1'b1; d_dm_op = 2'b11; end
          6'd24, 6'd25: begin
            d_regwrite = 1'b0; d_regdst = 1'b0; d_dm_en = 1'b1; d_dm_op = 2'b00;
            d_dm_signed = ~funct[0];
          end
          6'd26, 6'd27: begin
            d_regwrite = 1'b0; d_regdst = 1'b0; d_dm_en = 1'b1; d_dm_op = 2'b01;
            d_dm_signed = ~funct[0];
          end
          default: begin d_regwrite = 1'b0; d_regdst = 1'b0; end
        endcase
      end
      6'd1: begin
        if (rtf == 5'd0 || rtf == 5'd1 || rtf == 5'd16 || rtf == 5'd17) d_branch = 1'b1;
        if (rtf == 5'd16 || rtf == 5'd17) begin d_link = 1'b1; d_regwrite = 1'b1; end
      end
      6'd2:  d_jump = 1'b1;
      6'd3:  begin d_jump = 1'b1; d_link = 1'b1; d_regwrite = 1'b1; end
      6'd4, 6'd5, 6'd6, 6'd7: d_branch = 1'b1;
      6'd9:  begin d_alusrc = 1'b1; d_signed_imm = 1'b1; d_regwrite = 1'b1; d_alu = A_ADD;  end
      6'd10: begin d_alusrc = 1'b1; d_signed_imm = 1'b1; d_regwrite = 1'b1; d_alu = A_SLT;  end
      6'd11: begin d_alusrc = 1'b1; d_signed_imm = 1'b1; d_regwrite = 1'b1; d_alu = A_SLTU; end
      6'd12: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_alu = A_AND; end
      6'd13: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_alu = A_OR;  end
      6'd14: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_alu = A_XOR; end
      6'd15: begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_loadimmed = 1'b1; end
      6'd32, 6'd33, 6'd35, 6'd36, 6'd37: begin
        d_load = 1'b1; d_alusrc = 1'b1; d_signed_imm = 1'b1; d_regwrite = 1'b1;
        case (op)
          6'd32:   d_extend_op = 3'b111;
          6'd36:   d_extend_op = 3'b110;
          6'd33:   d_extend_op = 3'b101;
          6'd37:   d_extend_op = 3'b100;
          default: d_memtoreg  = 1'b1;
        endcase
      end
      6'd40, 6'd41, 6'd43: begin d_store = 1'b1; d_alusrc = 1'b1; d_signed_imm = 1'b1; end
      default: ;
    endcase
  end

  // ALU: operand B is rt or the extended immediate; shifts act on B.
  always_comb begin
    alu_b = rt_data;
    if (d_alusrc) alu_b = d_signed_imm ? {{16{instr[15]}}, instr[15:0]} : {16'd0, instr[15:0]};
    case (d_alu)
      A_SUB:   alu_result = rs_data - alu_b;
      A_AND:   alu_result = rs_data & alu_b;
      A_OR:    alu_result = rs_data | alu_b;
      A_XOR:   alu_result = rs_data ^ alu_b;
      A_SLT:   alu_result = ($signed(rs_data) < $signed(alu_b)) ? 32'd1 : 32'd0;
      A_SLTU:  alu_result = (rs_data < alu_b) ? 32'd1 : 32'd0;
      A_SLL:   alu_result = alu_b << shamt;
      A_SRL:   alu_result = alu_b >> shamt;
      A_SRA:   alu_result = $signed(alu_b) >>> shamt;
      A_SLLV:  alu_result = alu_b << rs_data[4:0];
      A_SRLV:  alu_result = alu_b >> rs_data[4:0];
      A_SRAV:  alu_result = $signed(alu_b) >>> rs_data[4:0];
      default: alu_result = rs_data + alu_b;
    endcase
  end

  // Branch condition; non-branch instructions report a zero result.
  always_comb begin
    case (op)
      6'd1:    cond = rtf[0] ? ~rs_data[31] : rs_data[31];
      6'd4:    cond = (rs_data == rt_data);
      6'd5:    cond = (rs_data != rt_data);
      6'd6:    cond = rs_data[31] | (rs_data == 32'd0);
      6'd7:    cond = ~rs_data[31] & (rs_data != 32'd0);
      default: cond = (alu_result == 32'd0);
    endcase
  end

  // Datapath strobes gated by sequencer state.
  always_comb begin
    memread = 1'b0; memwrite = 1'b0; regwrite = 1'b0; regdst = 1'b0; alusrc = 1'b0;
    signed_imm = 1'b0; branch = 1'b0; jump = 1'b0; regtojump = 1'b0; link = 1'b0;
    pctoadd = 1'b0; pcwrite = 1'b0; inwrite = 1'b0; memtoreg = 1'b0; loadimmed = 1'b0;
    hitoreg = 1'b0; lotoreg = 1'b0; dm_en = 1'b0; dm_signed = 1'b0; dm_op = 2'b00;
    extend_op = 3'b000; byteenable = 4'b0000;
    if (state_q == S_EXEC1 || state_q == S_EXEC2) begin
      alusrc = d_alusrc; signed_imm = d_signed_imm; regdst = d_regdst;
      link = d_link; extend_op = d_extend_op;
    end
    case (state_q)
      S_FETCH:  begin memread = 1'b1; pctoadd = 1'b1; byteenable = 4'b1111; end
      S_DECODE: inwrite = 1'b1;
      S_EXEC1: begin
        memread = d_load; memwrite = d_store; branch = d_branch;
        jump = d_jump; regtojump = d_regtojump;
        if (d_load) byteenable = 4'b1111;
        if (d_store) begin
          case (op)
            6'd40:   byteenable = 4'b1000 >> addr_lo;
            6'd41:   byteenable = addr_lo[1] ? 4'b0011 : 4'b1100;
            default: byteenable = 4'b1111;
          endcase
        end
      end
      S_EXEC2: begin
        pcwrite = 1'b1; regwrite = d_regwrite; memtoreg = d_memtoreg;
        loadimmed = d_loadimmed; hitoreg = d_hitoreg; lotoreg = d_lotoreg;
        dm_en = d_dm_en; dm_signed = d_dm_signed; dm_op = d_dm_op;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_ctrl_exec.sv
// tb/tb_mips_ctrl_exec.sv - directed self-checking bench for mips_ctrl_exec
module tb_mips_ctrl_exec;

  logic        clk = 1'b0;
  logic        reset, waitrequest, pc_zero;
  logic [31:0] instr_in, rs_data, rt_data;
  logic [1:0]  addr_lo;
  logic [2:0]  state;
  logic        active, cond;
  logic [31:0] instr, alu_result;
  logic        memread, memwrite, regwrite, regdst, alusrc, signed_imm, branch, jump;
  logic        regtojump, link, pctoadd, pcwrite, inwrite, memtoreg, loadimmed;
  logic        hitoreg, lotoreg, dm_en, dm_signed;
  logic [1:0]  dm_op;
  logic [2:0]  extend_op;
  logic [3:0]  byteenable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_ctrl_exec dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .pc_zero(pc_zero),
    .instr_in(instr_in), .rs_data(rs_data), .rt_data(rt_data), .addr_lo(addr_lo),
    .state(state), .active(active), .instr(instr), .alu_result(alu_result), .cond(cond),
    .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
    .alusrc(alusrc), .signed_imm(signed_imm), .branch(branch), .jump(jump),
    .regtojump(regtojump), .link(link), .pctoadd(pctoadd), .pcwrite(pcwrite),
    .inwrite(inwrite), .memtoreg(memtoreg), .loadimmed(loadimmed), .hitoreg(hitoreg),
    .lotoreg(lotoreg), .dm_en(dm_en), .dm_signed(dm_signed), .dm_op(dm_op),
    .extend_op(extend_op), .byteenable(byteenable)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present the instruction, advance through DECODE into EXEC1.
  task automatic to_exec1(input logic [31:0] iw);
    instr_in = iw;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; waitrequest = 1'b0; pc_zero = 1'b0;
    instr_in = 32'd0; rs_data = 32'd0; rt_data = 32'd0; addr_lo = 2'b00;
    #12;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active); end
    total++; if (instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
    reset = 1'b1;
  endtask

  task automatic test_sequencer();
    logic [2:0] exp_seq [5];
    exp_seq[0] = 3'd1; exp_seq[1] = 3'd2; exp_seq[2] = 3'd3; exp_seq[3] = 3'd4; exp_seq[4] = 3'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (state !== exp_seq[i]) begin bad++; $display("FAIL seq_state[%0d] got=%0d want=%0d", i, state, exp_seq[i]); end
      total++; if (active !== 1'b1) begin bad++; $display("FAIL seq_active[%0d] got=%b want=1", i, active); end
    end
    total++; if (memread !== 1'b1 || pctoadd !== 1'b1 || byteenable !== 4'b1111) begin
      bad++; $display("FAIL fetch_strobes got=%b%b%b want=111111", memread, pctoadd, byteenable); end
    step();
    total++; if (inwrite !== 1'b1) begin bad++; $display("FAIL decode_inwrite got=%b want=1", inwrite); end
    waitrequest = 1'b1;
    step();
    step();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL stall_state got=%0d want=2", state); end
    waitrequest = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_pc_zero();
    pc_zero = 1'b1;
    step();
    total++; if (state !== 3'd0 || active !== 1'b0) begin
      bad++; $display("FAIL pcz_fetch got=%0d/%b want=0/0", state, active); end
    pc_zero = 1'b0;
    step();
    step();
    step();
    step();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL pcz_reach_exec2 got=%0d want=4", state); end
    pc_zero = 1'b1;
    step();
    total++; if (state !== 3'd0 || active !== 1'b0) begin
      bad++; $display("FAIL pcz_exec2 got=%0d/%b want=0/0", state, active); end
    pc_zero = 1'b0;
    step();
  endtask

  task automatic test_alu();
    rs_data = 32'hFFFF_FFFF; rt_data = 32'd2;
    to_exec1(32'h0000_0021);
    total++; if (alu_result !== 32'h0000_0001) begin bad++; $display("FAIL addu got=%h want=00000001", alu_result); end
    total++; if (instr !== 32'h0000_0021) begin bad++; $display("FAIL instr_latch got=%h want=00000021", instr); end
    total++; if (cond !== 1'b0) begin bad++; $display("FAIL addu_cond got=%b want=0", cond); end
    step();
    total++; if (regwrite !== 1'b1 || regdst !== 1'b1 || pcwrite !== 1'b1) begin
      bad++; $display("FAIL addu_exec2 got=%b%b%b want=111", regwrite, regdst, pcwrite); end
    step();
    rs_data = 32'h8000_0000; rt_data = 32'd1;
    to_exec1(32'h0000_002A);
    total++; if (alu_result !== 32'd1) begin bad++; $display("FAIL slt got=%h want=00000001", alu_result); end
    step(); step();
    to_exec1(32'h0000_002B);
    total++; if (alu_result !== 32'd0) begin bad++; $display("FAIL sltu got=%h want=00000000", alu_result); end
    total++; if (cond !== 1'b1) begin bad++; $display("FAIL sltu_zero_cond got=%b want=1", cond); end
    step(); step();
    rt_data = 32'h8000_0000;
    to_exec1(32'h0000_0103);
    total++; if (alu_result !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h want=f8000000", alu_result); end
    step(); step();
  endtask

  task automatic test_immediate();
    rs_data = 32'hFFFF_FFFF;
    to_exec1(32'h3000_FFFF);
    total++; if (alu_result !== 32'h0000_FFFF) begin bad++; $display("FAIL andi got=%h want=0000ffff", alu_result); end
    total++; if (alusrc !== 1'b1 || signed_imm !== 1'b0) begin
      bad++; $display("FAIL andi_ctl got=%b%b want=10", alusrc, signed_imm); end
    step(); step();
  endtask

  task automatic test_store();
    rs_data = 32'h0000_0100; addr_lo = 2'b01;
    to_exec1(32'hA000_FFFC);
    total++; if (memwrite !== 1'b1 || memread !== 1'b0) begin
      bad++; $display("FAIL sb_we got=%b%b want=10", memwrite, memread); end
    total++; if (byteenable !== 4'b0100) begin bad++; $display("FAIL sb_be got=%b want=0100", byteenable); end
    total++; if (alu_result !== 32'h0000_00FC) begin bad++; $display("FAIL sb_addr got=%h want=000000fc", alu_result); end
    step(); step();
    addr_lo = 2'b10;
    to_exec1(32'hA400_0000);
    total++; if (byteenable !== 4'b0011) begin bad++; $display("FAIL sh_be got=%b want=0011", byteenable); end
    step(); step();
    to_exec1(32'hAC00_0000);
    total++; if (byteenable !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b want=1111", byteenable); end
    step(); step();
  endtask

  task automatic test_load();
    to_exec1(32'h8000_0000);
    total++; if (memread !== 1'b1 || byteenable !== 4'b1111) begin
      bad++; $display("FAIL lb_exec1 got=%b/%b want=1/1111", memread, byteenable); end
    step();
    total++; if (regwrite !== 1'b1 || extend_op !== 3'b111 || memtoreg !== 1'b0) begin
      bad++; $display("FAIL lb_exec2 got=%b/%b/%b want=1/111/0", regwrite, extend_op, memtoreg); end
    step();
  endtask

  task automatic test_branch();
    rs_data = 32'd0;
    to_exec1(32'h0401_0000);
    total++; if (cond !== 1'b1 || branch !== 1'b1) begin
      bad++; $display("FAIL bgez got=%b/%b want=1/1", cond, branch); end
    step(); step();
    to_exec1(32'h0400_0000);
    total++; if (cond !== 1'b0) begin bad++; $display("FAIL bltz got=%b want=0", cond); end
    step(); step();
    rs_data = 32'd5; rt_data = 32'd5;
    to_exec1(32'h1400_0000);
    total++; if (cond !== 1'b0) begin bad++; $display("FAIL bne got=%b want=0", cond); end
    step(); step();
  endtask

  task automatic test_jump();
    to_exec1(32'h0C00_0000);
    total++; if (jump !== 1'b1) begin bad++; $display("FAIL jal_jump got=%b want=1", jump); end
    step();
    total++; if (link !== 1'b1 || regwrite !== 1'b1 || regdst !== 1'b0) begin
      bad++; $display("FAIL jal_exec2 got=%b%b%b want=110", link, regwrite, regdst); end
    step();
    to_exec1(32'h0000_0008);
    total++; if (jump !== 1'b1 || regtojump !== 1'b1) begin
      bad++; $display("FAIL jr_exec1 got=%b%b want=11", jump, regtojump); end
    step();
    total++; if (regwrite !== 1'b0 || pcwrite !== 1'b1) begin
      bad++; $display("FAIL jr_exec2 got=%b%b want=01", regwrite, pcwrite); end
    step();
  endtask

  task automatic test_async_reset();
    to_exec1(32'h0000_0021);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL ar_reach_exec1 got=%0d want=3", state); end
    #2 reset = 1'b0;
    #1;
    total++; if (state !== 3'd0 || active !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%0d/%b want=0/0", state, active); end
    #1 reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequencer();
    test_pc_zero();
    test_alu();
    test_immediate();
    test_store();
    test_load();
    test_branch();
    test_jump();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
